// File: rtl/keccak_pkg.sv
// keccak_pkg: rho offset table and lane-index helpers shared by the rho stream stage
package keccak_pkg;
  localparam int RHO [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } lane_xy_t;
  typedef logic [24:0][5:0] rho_tab_t;
  function automatic lane_xy_t lane_xy(input int k);
    return '{x: 3'(k / 5), y: 3'(k % 5)};
  endfunction
  // Offsets in lane order k = 5*x + y, already reduced mod the lane width
  function automatic rho_tab_t rho_tab(input int w);
    rho_tab_t t;
    lane_xy_t p;
    for (int k = 0; k < 25; k++) begin
      p = lane_xy(k);
      t[k] = 6'(RHO[p.x][p.y] % w);
    end
    return t;
  endfunction
endpackage

// File: rtl/rho_lane_stream_if.sv
// rho_lane_stream_if: valid/ready input and output beat channels of the rho stream stage
interface rho_lane_stream_if #(
  parameter int LANE_W = 64,
  parameter int LPC = 5
);
  logic in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last;
  logic [LPC-1:0][LANE_W-1:0] in_lanes, out_lanes;
  modport master (
    output in_valid, in_lanes, in_last, out_ready,
    input in_ready, out_valid, out_lanes, out_last
  );
  modport slave (
    input in_valid, in_lanes, in_last, out_ready,
    output in_ready, out_valid, out_lanes, out_last
  );
endinterface

// File: rtl/rho_lane_rot.sv
// rho_lane_rot: combinational left-rotate of one lane by a runtime offset
module rho_lane_rot #(
  parameter int W = 64,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] sh,
  output logic [W-1:0]  dout
);
  assign dout = W'(({din, din} << sh) >> W);
endmodule

// File: rtl/rho_lane_stream.sv
// rho_lane_stream: streams Keccak lanes through the rho rotations; define RHO_PROTOCOL_CHK_EN for a sticky in_last check
module rho_lane_stream
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int LPC = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  rho_lane_stream_if.slave   bus,
  output logic               err
);
  localparam int BEATS = 25 / LPC;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW = $clog2(LANE_W);
  localparam rho_tab_t OFF = rho_tab(LANE_W);
  if (!(LPC inside {1, 5, 25})) begin : g_bad_lpc
    $error("rho_lane_stream: LPC must be 1, 5 or 25");
  end
  if (!(LANE_W inside {8, 16, 32, 64})) begin : g_bad_w
    $error("rho_lane_stream: LANE_W must be 8, 16, 32 or 64");
  end
  logic [CW-1:0] cnt;
  logic in_hs, at_last;
  logic [LPC-1:0][LANE_W-1:0] rot;
  assign bus.in_ready = !rst_n || !bus.out_valid || bus.out_ready;
  assign in_hs = bus.in_valid && bus.in_ready;
  assign at_last = cnt == CW'(BEATS - 1);
  for (genvar j = 0; j < LPC; j++) begin : g_slot
    logic [4:0] idx;
    assign idx = 5'(int'(cnt) * LPC + j);
    rho_lane_rot #(.W(LANE_W)) u_rot (
      .din (bus.in_lanes[j]),
      .sh  (OFF[idx][SW-1:0]),
      .dout(rot[j])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_lanes <= '0;
    end else if (in_hs) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
      bus.out_valid <= 1'b1;
      bus.out_last <= at_last;
      bus.out_lanes <= rot;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
`ifdef RHO_PROTOCOL_CHK_EN
  // The counter keeps its own phase; a mismatched in_last only raises the flag
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (in_hs && bus.in_last != at_last) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rho_lane_stream.sv
// tb_rho_lane_stream: directed checks of the rho stream stage at 64x5 and 8x1 configurations
module tb_rho_lane_stream;
  localparam int RHO_K [25] = '{0, 36, 3, 41, 18, 1, 44, 10, 45, 2, 62, 6, 43, 15, 61,
                               28, 55, 25, 21, 56, 27, 20, 39, 8, 14};
  logic clk = 1'b0;
  logic rst_n;
  logic a_err, b_err;
  int n_cmp = 0, n_bad = 0, bcnt = 0;
  logic exp_err = 1'b0;
  bit chk_en;
  logic [4:0][63:0] l, e;
  logic el;
  always #5 clk = ~clk;
  rho_lane_stream_if #(.LANE_W(64), .LPC(5)) a_if ();
  rho_lane_stream_if #(.LANE_W(8), .LPC(1)) b_if ();
  rho_lane_stream #(.LANE_W(64), .LPC(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave), .err(a_err));
  rho_lane_stream #(.LANE_W(8), .LPC(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave), .err(b_err));
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0][63:0] mk(input int s);
    logic [4:0][63:0] r;
    for (int j = 0; j < 5; j++) r[j] = 64'h9E3779B97F4A7C15 * 64'(s * 5 + j + 1);
    return r;
  endfunction
  function automatic logic [4:0][63:0] model(input int b, input logic [4:0][63:0] v);
    logic [4:0][63:0] r;
    int sh;
    for (int j = 0; j < 5; j++) begin
      sh = RHO_K[b * 5 + j] % 64;
      r[j] = sh == 0 ? v[j] : (v[j] << sh) | (v[j] >> (64 - sh));
    end
    return r;
  endfunction
  // Drives one beat on DUT A, tracking the expected lane group and out_last
  task automatic send_a(input logic [4:0][63:0] v, input logic lst);
    a_if.in_valid = 1'b1;
    a_if.in_lanes = v;
    a_if.in_last = lst;
    if (chk_en && lst != (bcnt == 4)) exp_err = 1'b1;
    e = model(bcnt, v);
    el = bcnt == 4;
    bcnt = (bcnt + 1) % 5;
  endtask
  initial begin
`ifdef RHO_PROTOCOL_CHK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst_n = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_lanes = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_lanes = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;
    #1;
    check("rst_in_ready_early", a_if.in_ready, 1);
    tick(); tick();
    check("rst_in_ready", a_if.in_ready, 1);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_out_last", a_if.out_last, 0);
    check("rst_out_lanes", a_if.out_lanes, 0);
    check("rst_err", a_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      l = mk(i);
      if (i == 0) l[1] = 64'h1;
      send_a(l, bcnt == 4);
      tick();
      check($sformatf("stream%0d_lanes", i), a_if.out_lanes, e);
      check($sformatf("stream%0d_last", i), a_if.out_last, el);
      check($sformatf("stream%0d_valid", i), a_if.out_valid, 1);
      if (i == 0) check("slot1_rot36", a_if.out_lanes[1], 64'h0000_0010_0000_0000);
      if (i == 5) check("restart_slot0_rot0", a_if.out_lanes[0], l[0]);
    end
    a_if.in_valid = 1'b0;
    tick();
    check("drain_valid", a_if.out_valid, 0);
    a_if.out_ready = 1'b0;
    send_a(mk(10), 1'b0);
    tick();
    l = e;
    send_a(mk(11), 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_in_ready", i), a_if.in_ready, 0);
      check($sformatf("stall%0d_valid", i), a_if.out_valid, 1);
      check($sformatf("stall%0d_lanes", i), a_if.out_lanes, l);
      check($sformatf("stall%0d_last", i), a_if.out_last, 0);
      tick();
    end
    a_if.out_ready = 1'b1;
    #1;
    check("release_in_ready", a_if.in_ready, 1);
    tick();
    a_if.in_valid = 1'b0;
    check("release_lanes", a_if.out_lanes, e);
    check("release_valid", a_if.out_valid, 1);
    tick();
    check("release_drain", a_if.out_valid, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", a_if.out_valid, 0);
    check("midrst_err", a_err, 0);
    check("midrst_in_ready", a_if.in_ready, 1);
    rst_n = 1'b1;
    bcnt = 0;
    exp_err = 1'b0;
    send_a(mk(20), 1'b0);
    tick();
    a_if.in_valid = 1'b0;
    check("postrst_lanes", a_if.out_lanes, e);
    check("postrst_last", a_if.out_last, 0);
    for (int i = 1; i < 5; i++) begin
      send_a(mk(30 + i), i == 2 || i == 4);
      tick();
      check($sformatf("proto%0d_lanes", i), a_if.out_lanes, e);
      check($sformatf("proto%0d_last", i), a_if.out_last, el);
      check($sformatf("proto%0d_err", i), a_err, exp_err);
    end
    a_if.in_valid = 1'b0;
    tick();
    check("proto_err_sticky", a_err, exp_err);
    b_if.in_valid = 1'b1;
    b_if.in_lanes = 8'hA5;
    tick();
    check("w8_k0", b_if.out_lanes, 8'hA5);
    b_if.in_lanes = 8'h01;
    tick();
    b_if.in_valid = 1'b0;
    check("w8_k1", b_if.out_lanes, 8'h10);
    check("w8_last", b_if.out_last, 0);
    check("w8_err", b_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rho_lane_stream.md
RHO_LANE_STREAM -- requirements
Module: rho_lane_stream

Interface
REQ-001 SHALL have parameter LANE_W, default 64: lane width w; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter LPC, default 5: lanes per beat; legal values 1, 5, 25; any other value is an elaboration error.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_lanes  input  LPC*LANE_W  LPC lanes, packed as [LPC][LANE_W]; element j is lane slot j.
REQ-008 SHALL have port in_last  input  1  sender marks the final beat of a 25-lane state.
REQ-009 SHALL have port out_valid  output  1  output beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output beat.
REQ-011 SHALL have port out_lanes  output  LPC*LANE_W  rotated lanes, same packing as in_lanes.
REQ-012 SHALL have port out_last  output  1  final beat of the state.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL take lanes in order k = 5*x + y (x outer, y inner), k = 0..24; beat b carries lanes k = b*LPC + j.
REQ-015 SHALL use BEATS = 25/LPC beats per state and a beat counter running 0..BEATS-1.
REQ-016 SHALL advance the beat counter on each input handshake and wrap it to 0 after beat BEATS-1.
REQ-017 SHALL left-rotate each lane by OFFSET[x][y] mod LANE_W, using the FIPS 202 rho table ([0][*] = 0,36,3,41,18; [1][*] = 1,44,10,45,2; [2][*] = 62,6,43,15,61; [3][*] = 28,55,25,21,56; [4][*] = 27,20,39,8,14).
REQ-018 SHALL pass a lane unchanged when its effective offset is 0.
REQ-019 SHALL implement a single registered output stage: an accepted beat appears on out_* one cycle after the handshake.
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational), so back-to-back transfers run at one beat per cycle.
REQ-021 SHALL set out_last when the accepted beat had counter value BEATS-1; with LPC=25, out_last is 1 on every beat.
REQ-022 SHALL hold out_lanes, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when input and output handshakes occur in the same cycle, load the new beat into the output register (no bubble).
REQ-024 SHALL clear out_valid after an output handshake that has no concurrent input handshake.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set out_valid=0, out_last=0, out_lanes=0, err=0 and beat counter=0.
REQ-026 SHALL hold in_ready=1 throughout reset.
REQ-027 SHALL, on reset mid-state, discard any partial state; the next accepted beat is lane group 0.

Configuration
REQ-028 SHALL, with RHO_PROTOCOL_CHK_EN defined, set err=1 on any input handshake where in_last differs from (counter==BEATS-1), and hold err at 1 until reset.
REQ-029 SHALL process data identically on an in_last mismatch: the counter is not resynchronised.
REQ-030 SHALL, with RHO_PROTOCOL_CHK_EN undefined, tie err to 0 and ignore in_last.

Structure
REQ-031 SHALL place the 5x5 rho offset table and the lane-index-to-(x,y) helper in keccak_pkg.
REQ-032 SHALL instantiate LPC copies of sub-module rho_lane_rot, a combinational rotate of LANE_W with a per-instance offset.
REQ-033 SHALL compute each slot's offset from the beat counter by a table lookup, with the mod LANE_W reduction applied in elaboration-time constants.

Verification
REQ-034 SHALL cover: LANE_W=64, LPC=5, beat 0 lane y=1 = 0x1 -> out slot 1 = 0x0000_0010_0000_0000 (rotate 36), one cycle later.
REQ-035 SHALL cover: LANE_W=8, LPC=1, lane k=1 = 0x01 -> out 0x10 (36 mod 8 = 4); lane k=0 = 0xA5 -> 0xA5.
REQ-036 SHALL cover: LPC=5, five consecutive beats -> out_last=1 only on the fifth output; a sixth beat restarts with lane group 0 offsets.
REQ-037 SHALL cover: out_ready held 0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; on release, one transfer per cycle with no loss or duplication.
REQ-038 SHALL cover: rst_n pulsed low after beat 2 -> out_valid=0, err=0; the next beat is rotated with group-0 offsets.
REQ-039 SHALL cover: with RHO_PROTOCOL_CHK_EN, LPC=5, in_last=1 on beat 2 -> err=1 from the next cycle and sticky, data still correct; without the macro, err stays 0.
